mc_control_fsm: RTL and testbench

- Multicycle MIPS control unit sitting directly upstream of the 32-bit ALU.
- Decodes op/funct from the instruction register and sequences fetch/decode/execute/memory/writeback states.
- Drives the ALU's 3-bit alucontrol and all datapath mux selects and write enables.
- Consumes the ALU zero flag for branches and handshakes with a variable-latency memory through mem_ready.

---
 rtl/mc_ctrl_pkg.sv | 71 +++++++
 rtl/mc_alu_decoder.sv | 23 ++
 rtl/mc_control_fsm.sv | 170 +++++++++++++++++
 tb/tb_mc_control_fsm.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: FSM states, opcode/funct
// constants, ALU control codes and the datapath control bundle.
package mc_ctrl_pkg;

  localparam int unsigned OP_W      = 6;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned ALUCTRL_W = 3;
  localparam int unsigned STATE_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_ORIEX   = 4'd13
  } state_e;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;

  localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'b101010;

  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b110;
  localparam logic [ALUCTRL_W-1:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic                 iord;
    logic                 memwrite;
    logic                 irwrite;
    logic                 regdst;
    logic                 memtoreg;
    logic                 regwrite;
    logic                 alusrca;
    logic [1:0]           alusrcb;
    logic [1:0]           pcsrc;
    logic                 pcen;
    logic [ALUCTRL_W-1:0] alucontrol;
    logic                 illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_alu_decoder.sv
// R-type funct to ALU control decoder; o_valid flags a supported funct.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [FUNCT_W-1:0]   i_funct,
  output logic [ALUCTRL_W-1:0] o_alucontrol,
  output logic                 o_valid
);

  always_comb begin
    o_alucontrol = ALU_AND;
    o_valid      = 1'b1;
    case (i_funct)
      FN_ADD:  o_alucontrol = ALU_ADD;
      FN_SUB:  o_alucontrol = ALU_SUB;
      FN_AND:  o_alucontrol = ALU_AND;
      FN_OR:   o_alucontrol = ALU_OR;
      FN_SLT:  o_alucontrol = ALU_SLT;
      default: o_valid      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS control FSM driving ALU control, mux selects and write enables.
// Define MC_CTRL_ORI_EN to decode ori (ORIEX state plus zeroext output).
module mc_control_fsm
  import mc_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [OP_W-1:0]      op,
  input  logic [FUNCT_W-1:0]   funct,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [1:0]           pcsrc,
  output logic                 pcen,
  output logic [ALUCTRL_W-1:0] alucontrol,
`ifdef MC_CTRL_ORI_EN
  output logic                 zeroext,
`endif
  output logic                 illegal_op
);

  state_e               r_state;
  state_e               w_next_state;
  state_e               w_decode_state;
  logic                 w_op_known;
  logic [ALUCTRL_W-1:0] w_funct_alu;
  logic                 w_funct_valid;
  ctrl_t                w_ctrl;
`ifdef MC_CTRL_ORI_EN
  logic                 w_zeroext;
`endif

  mc_alu_decoder u_alu_decoder (
    .i_funct      (funct),
    .o_alucontrol (w_funct_alu),
    .o_valid      (w_funct_valid)
  );

  // Opcode to first post-decode state; FETCH means undecodable.
  always_comb begin
    w_decode_state = S_FETCH;
    case (op)
      OP_LW, OP_SW: w_decode_state = S_MEMADR;
      OP_RTYPE:     w_decode_state = S_EXECUTE;
      OP_BEQ:       w_decode_state = S_BRANCH;
      OP_ADDI:      w_decode_state = S_ADDIEX;
      OP_J:         w_decode_state = S_JUMP;
`ifdef MC_CTRL_ORI_EN
      OP_ORI:       w_decode_state = S_ORIEX;
`endif
      default:      w_decode_state = S_FETCH;
    endcase
  end

  assign w_op_known = (w_decode_state != S_FETCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_IDLE:    w_next_state = S_FETCH;
      S_FETCH:   w_next_state = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:  w_next_state = w_decode_state;
      S_MEMADR:  w_next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   w_next_state = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   w_next_state = mem_ready ? S_FETCH : S_MEMWR;
      S_EXECUTE: w_next_state = w_funct_valid ? S_ALUWB : S_FETCH;
      S_ADDIEX:  w_next_state = S_ADDIWB;
`ifdef MC_CTRL_ORI_EN
      S_ORIEX:   w_next_state = S_ADDIWB;
`endif
      default:   w_next_state = S_FETCH;
    endcase
  end

  // Outputs from state; only FETCH/BRANCH enables and illegal pulses look at inputs.
  always_comb begin
    w_ctrl = '0;
`ifdef MC_CTRL_ORI_EN
    w_zeroext = 1'b0;
`endif
    case (r_state)
      S_FETCH: begin
        w_ctrl.alusrcb    = SRCB_FOUR;
        w_ctrl.alucontrol = ALU_ADD;
        w_ctrl.pcsrc      = PCSRC_ALU;
        w_ctrl.irwrite    = mem_ready;
        w_ctrl.pcen       = mem_ready;
      end
      S_DECODE: begin
        w_ctrl.alusrcb    = SRCB_IMMSH;
        w_ctrl.alucontrol = ALU_ADD;
        w_ctrl.illegal_op = ~w_op_known;
      end
      S_MEMADR, S_ADDIEX: begin
        w_ctrl.alusrca    = 1'b1;
        w_ctrl.alusrcb    = SRCB_IMM;
        w_ctrl.alucontrol = ALU_ADD;
      end
      S_MEMRD: w_ctrl.iord = 1'b1;
      S_MEMWB: begin
        w_ctrl.memtoreg = 1'b1;
        w_ctrl.regwrite = 1'b1;
      end
      S_MEMWR: begin
        w_ctrl.iord     = 1'b1;
        w_ctrl.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        w_ctrl.alusrca    = 1'b1;
        w_ctrl.alusrcb    = SRCB_REG;
        w_ctrl.alucontrol = w_funct_alu;
        w_ctrl.illegal_op = ~w_funct_valid;
      end
      S_ALUWB: begin
        w_ctrl.regdst   = 1'b1;
        w_ctrl.regwrite = 1'b1;
      end
      S_BRANCH: begin
        w_ctrl.alusrca    = 1'b1;
        w_ctrl.alusrcb    = SRCB_REG;
        w_ctrl.alucontrol = ALU_SUB;
        w_ctrl.pcsrc      = PCSRC_ALUOUT;
        w_ctrl.pcen       = zero;
      end
      S_ADDIWB: w_ctrl.regwrite = 1'b1;
      S_JUMP: begin
        w_ctrl.pcsrc = PCSRC_JUMP;
        w_ctrl.pcen  = 1'b1;
      end
`ifdef MC_CTRL_ORI_EN
      S_ORIEX: begin
        w_ctrl.alusrca    = 1'b1;
        w_ctrl.alusrcb    = SRCB_IMM;
        w_ctrl.alucontrol = ALU_OR;
        w_zeroext         = 1'b1;
      end
`endif
      default: w_ctrl = '0;
    endcase
  end

  assign iord       = w_ctrl.iord;
  assign memwrite   = w_ctrl.memwrite;
  assign irwrite    = w_ctrl.irwrite;
  assign regdst     = w_ctrl.regdst;
  assign memtoreg   = w_ctrl.memtoreg;
  assign regwrite   = w_ctrl.regwrite;
  assign alusrca    = w_ctrl.alusrca;
  assign alusrcb    = w_ctrl.alusrcb;
  assign pcsrc      = w_ctrl.pcsrc;
  assign pcen       = w_ctrl.pcen;
  assign alucontrol = w_ctrl.alucontrol;
  assign illegal_op = w_ctrl.illegal_op;
`ifdef MC_CTRL_ORI_EN
  assign zeroext    = w_zeroext;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: instruction table expanded into a
// per-cycle expected-output scoreboard, plus hand-written reset sequences.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, pcen, illegal_op;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic       zeroext;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .pcsrc      (pcsrc),
    .pcen       (pcen),
    .alucontrol (alucontrol),
`ifdef MC_CTRL_ORI_EN
    .zeroext    (zeroext),
`endif
    .illegal_op (illegal_op)
  );
`ifndef MC_CTRL_ORI_EN
  assign zeroext = 1'b0;
`endif

  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic       illegal_op;
    logic       zeroext;
  } out_t;

  typedef struct {
    string tag;
    out_t  exp;
    out_t  care;
  } sb_t;

  typedef enum int {
    P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR, P_EXEC,
    P_ALUWB, P_BRANCH, P_ADDIEX, P_ADDIWB, P_JUMP, P_ORIEX
  } phase_e;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] funct;
    logic       z;
    int         fw;
    int         mw;
    int         exp_rw;
    int         exp_mwc;
    int         exp_ill;
  } vec_t;

  out_t act;
  sb_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rw_cnt = 0;
  int   mw_cnt = 0;
  int   ill_cnt = 0;
  vec_t vecs[16];

  assign act = '{iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
                 alusrcb, pcsrc, pcen, alucontrol, illegal_op, zeroext};

  // Reference outputs for each control step.
  function automatic out_t exp_of(phase_e ph, logic mr, logic z, logic [2:0] ac, logic ill);
    out_t o;
    o = '0;
    case (ph)
      P_FETCH:  begin o.irwrite = mr; o.pcen = mr; o.alusrcb = 2'b01; o.alucontrol = 3'b010; end
      P_DECODE: begin o.alusrcb = 2'b11; o.alucontrol = 3'b010; o.illegal_op = ill; end
      P_MEMADR: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 3'b010; end
      P_MEMRD:  o.iord = 1'b1;
      P_MEMWB:  begin o.memtoreg = 1'b1; o.regwrite = 1'b1; end
      P_MEMWR:  begin o.iord = 1'b1; o.memwrite = 1'b1; end
      P_EXEC:   begin o.alusrca = 1'b1; o.alucontrol = ac; o.illegal_op = ill; end
      P_ALUWB:  begin o.regdst = 1'b1; o.regwrite = 1'b1; end
      P_BRANCH: begin o.alusrca = 1'b1; o.alucontrol = 3'b110; o.pcsrc = 2'b01; o.pcen = z; end
      P_ADDIEX: begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 3'b010; end
      P_ADDIWB: o.regwrite = 1'b1;
      P_JUMP:   begin o.pcsrc = 2'b10; o.pcen = 1'b1; end
      P_ORIEX:  begin o.alusrca = 1'b1; o.alusrcb = 2'b10; o.alucontrol = 3'b001; o.zeroext = 1'b1; end
      default:  o = '0;
    endcase
    return o;
  endfunction

  function automatic logic op_known(logic [5:0] o);
    case (o)
      6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010: return 1'b1;
`ifdef MC_CTRL_ORI_EN
      6'b001101: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  task automatic check_out(input string tag, input out_t got, input out_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // One clock of stimulus: drive inputs just after the edge, queue the expected outputs.
  task automatic step(input string tag, input phase_e ph, input logic mr, input logic z,
                      input logic [2:0] ac, input logic ill, input logic ac_care);
    sb_t e;
    @(posedge clk);
    #1;
    mem_ready = mr;
    zero      = z;
    e.tag  = tag;
    e.exp  = exp_of(ph, mr, z, ac, ill);
    e.care = '1;
    if (!ac_care) e.care.alucontrol = 3'b000;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    sb_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ((act & e.care) !== (e.exp & e.care)) begin
        errors++;
        $display("FAIL %s: outputs %h expected %h (mask %h)", e.tag, act, e.exp, e.care);
      end
      if (regwrite)   rw_cnt++;
      if (memwrite)   mw_cnt++;
      if (illegal_op) ill_cnt++;
    end
  end

  task automatic run_instr(input vec_t v);
    logic [2:0] ac;
    logic       fv;
    for (int i = 0; i < v.fw; i++) step({v.name, " fetch wait"}, P_FETCH, 1'b0, rb(), 3'b0, 1'b0, 1'b1);
    step({v.name, " fetch"}, P_FETCH, 1'b1, rb(), 3'b0, 1'b0, 1'b1);
    op    = v.op;
    funct = v.funct;
    step({v.name, " decode"}, P_DECODE, rb(), rb(), 3'b0, ~op_known(v.op), 1'b1);
    if (op_known(v.op)) begin
      case (v.op)
        6'b100011: begin
          step({v.name, " memadr"}, P_MEMADR, rb(), rb(), 3'b0, 1'b0, 1'b1);
          for (int i = 0; i < v.mw; i++) step({v.name, " memrd wait"}, P_MEMRD, 1'b0, rb(), 3'b0, 1'b0, 1'b1);
          step({v.name, " memrd"}, P_MEMRD, 1'b1, rb(), 3'b0, 1'b0, 1'b1);
          step({v.name, " memwb"}, P_MEMWB, rb(), rb(), 3'b0, 1'b0, 1'b1);
        end
        6'b101011: begin
          step({v.name, " memadr"}, P_MEMADR, rb(), rb(), 3'b0, 1'b0, 1'b1);
          for (int i = 0; i < v.mw; i++) step({v.name, " memwr wait"}, P_MEMWR, 1'b0, rb(), 3'b0, 1'b0, 1'b1);
          step({v.name, " memwr"}, P_MEMWR, 1'b1, rb(), 3'b0, 1'b0, 1'b1);
        end
        6'b000000: begin
          fv = 1'b1;
          ac = 3'b000;
          case (v.funct)
            6'b100000: ac = 3'b010;
            6'b100010: ac = 3'b110;
            6'b100100: ac = 3'b000;
            6'b100101: ac = 3'b001;
            6'b101010: ac = 3'b111;
            default:   fv = 1'b0;
          endcase
          step({v.name, " execute"}, P_EXEC, rb(), rb(), ac, ~fv, fv);
          if (fv) step({v.name, " aluwb"}, P_ALUWB, rb(), rb(), 3'b0, 1'b0, 1'b1);
        end
        6'b000100: step({v.name, " branch"}, P_BRANCH, rb(), v.z, 3'b0, 1'b0, 1'b1);
        6'b001000: begin
          step({v.name, " addiex"}, P_ADDIEX, rb(), rb(), 3'b0, 1'b0, 1'b1);
          step({v.name, " addiwb"}, P_ADDIWB, rb(), rb(), 3'b0, 1'b0, 1'b1);
        end
        6'b000010: step({v.name, " jump"}, P_JUMP, rb(), rb(), 3'b0, 1'b0, 1'b1);
`ifdef MC_CTRL_ORI_EN
        6'b001101: begin
          step({v.name, " oriex"}, P_ORIEX, rb(), rb(), 3'b0, 1'b0, 1'b1);
          step({v.name, " addiwb"}, P_ADDIWB, rb(), rb(), 3'b0, 1'b0, 1'b1);
        end
`endif
        default: ;
      endcase
    end
    @(negedge clk);
    #1;
    check_int({v.name, " regwrite cycles"}, rw_cnt, v.exp_rw);
    check_int({v.name, " memwrite cycles"}, mw_cnt, v.exp_mwc);
    check_int({v.name, " illegal_op cycles"}, ill_cnt, v.exp_ill);
    rw_cnt  = 0;
    mw_cnt  = 0;
    ill_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{"lw",        6'b100011, 6'b000000, 1'b0, 0, 0, 1, 0, 0};
    vecs[1]  = '{"lw slow",   6'b100011, 6'b000000, 1'b0, 0, 3, 1, 0, 0};
    vecs[2]  = '{"sw",        6'b101011, 6'b000000, 1'b0, 0, 0, 0, 1, 0};
    vecs[3]  = '{"sw slow",   6'b101011, 6'b000000, 1'b0, 2, 2, 0, 3, 0};
    vecs[4]  = '{"add",       6'b000000, 6'b100000, 1'b0, 0, 0, 1, 0, 0};
    vecs[5]  = '{"sub",       6'b000000, 6'b100010, 1'b0, 1, 0, 1, 0, 0};
    vecs[6]  = '{"and",       6'b000000, 6'b100100, 1'b0, 0, 0, 1, 0, 0};
    vecs[7]  = '{"or",        6'b000000, 6'b100101, 1'b0, 0, 0, 1, 0, 0};
    vecs[8]  = '{"slt",       6'b000000, 6'b101010, 1'b0, 0, 0, 1, 0, 0};
    vecs[9]  = '{"bad funct", 6'b000000, 6'b000111, 1'b0, 0, 0, 0, 0, 1};
    vecs[10] = '{"beq taken", 6'b000100, 6'b000000, 1'b1, 0, 0, 0, 0, 0};
    vecs[11] = '{"beq not",   6'b000100, 6'b000000, 1'b0, 0, 0, 0, 0, 0};
    vecs[12] = '{"addi",      6'b001000, 6'b000000, 1'b0, 0, 0, 1, 0, 0};
    vecs[13] = '{"j",         6'b000010, 6'b000000, 1'b0, 1, 0, 0, 0, 0};
    vecs[14] = '{"bad op",    6'b111111, 6'b000000, 1'b0, 0, 0, 0, 0, 1};
`ifdef MC_CTRL_ORI_EN
    vecs[15] = '{"ori",       6'b001101, 6'b000000, 1'b0, 0, 0, 1, 0, 0};
`else
    vecs[15] = '{"ori",       6'b001101, 6'b000000, 1'b0, 0, 0, 0, 0, 1};
`endif

    reset     = 1'b0;
    mem_ready = 1'b1;
    zero      = 1'b1;
    op        = 6'b000000;
    funct     = 6'b000000;
    #3;
    check_out("outputs in reset", act, '0);
    @(posedge clk);
    #1;
    check_out("outputs in reset after edge", act, '0);
    reset = 1'b1;
    #1;
    check_out("idle after release", act, '0);

    foreach (vecs[i]) run_instr(vecs[i]);

    // Abort a store mid-MEMWR: memwrite must drop without waiting for a clock.
    step("rst sw fetch", P_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b1);
    op = 6'b101011;
    step("rst sw decode", P_DECODE, 1'b0, 1'b0, 3'b0, 1'b0, 1'b1);
    step("rst sw memadr", P_MEMADR, 1'b0, 1'b0, 3'b0, 1'b0, 1'b1);
    step("rst sw memwr wait", P_MEMWR, 1'b0, 1'b0, 3'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check_int("memwrite before reset", int'(memwrite), 1);
    reset = 1'b0;
    #1;
    check_out("outputs right after async reset", act, '0);
    @(posedge clk);
    #1;
    mem_ready = 1'b1;
    check_out("outputs held in reset", act, '0);
    reset = 1'b1;
    #1;
    check_out("idle after mid-instruction reset", act, '0);
    rw_cnt  = 0;
    mw_cnt  = 0;
    ill_cnt = 0;
    run_instr(vecs[13]);
    run_instr(vecs[0]);
    step("final fetch", P_FETCH, 1'b1, 1'b0, 3'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
